uart_tx_arbiter: RTL

Round-robin controller that shares the board UART transmit channel between several on-chip requesters. It sits between the design's byte producers and the FPGA wrapper's `txdata` / `txclk` / `txready` interface. It selects one requester and launches its byte with a single `txclk` pulse, then tracks `txready` until the UART is free again. It supports locked multi-byte packets and a busy-timeout error.

---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
//   Shared definitions for the UART transmit arbiter:
//   - ua_state_t         : arbiter FSM state encoding
//   - UA_N_REQ_MAX       : largest supported requester count
//   - UA_TIMEOUT_DEFAULT : default cycles to wait for the UART to go busy
package uart_arb_pkg;

  typedef enum logic [1:0] {
    UA_IDLE,
    UA_STROBE,
    UA_WAIT_BUSY,
    UA_WAIT_IDLE
  } ua_state_t;

  localparam int unsigned UA_N_REQ_MAX       = 8;
  localparam int unsigned UA_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Purely combinational rotate-priority encoder. The search starts at
//   index ptr and wraps from N-1 back to 0; the first set request wins.
// Ports:
//   req       in  N  request vector
//   ptr       in  W  index searched first
//   valid     out 1  at least one request is set
//   grant_idx out W  index of the winning request (0 when !valid)
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] grant_idx
);

  logic [W-1:0] idx;

  always_comb begin
    valid     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = W'((32'(ptr) + k) % N);
      if (!valid && req[idx]) begin
        valid     = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter sharing one UART transmit channel among N_REQ byte
//   producers. A winner's byte is registered onto txdata with a one-cycle
//   ack, then launched with a one-cycle txclk pulse; the FSM then follows
//   the synchronized txready until the UART is idle again. A byte granted
//   with req_last=0 locks the channel to that requester until its final
//   byte is granted (or it withdraws its request). If the UART never goes
//   busy after a launch, err pulses and the arbiter returns to IDLE.
// Ports:
//   clk       in  1        system clock, posedge
//   reset     in  1        synchronous, active-high
//   req       in  N_REQ    per-requester byte pending
//   req_data  in  8*N_REQ  byte i at [8i+7:8i]
//   req_last  in  N_REQ    byte is the last of its packet
//   ack       out N_REQ    one-cycle capture pulse for the granted requester
//   txdata    out 8        byte presented to the UART
//   txclk     out 1        one-cycle launch pulse
//   txready   in  1        UART idle (asynchronous to clk)
//   busy      out 1        FSM not in IDLE
//   owner     out W        index of last-granted requester
//   err       out 1        one-cycle pulse on busy timeout
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = UA_TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [8*N_REQ-1:0]        req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          ack,
  output logic [7:0]                txdata,
  output logic                      txclk,
  input  logic                      txready,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      err
);

  localparam int unsigned W  = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  ua_state_t      state;
  logic           txready_m;
  logic           txready_s;
  logic [W-1:0]   ptr;
  logic           locked;
  logic [CW-1:0]  cnt;

  logic [7:0]       req_byte [N_REQ];
  logic [N_REQ-1:0] cand;
  logic             pick_valid;
  logic [W-1:0]     pick_idx;

  for (genvar k = 0; k < N_REQ; k++) begin : g_bytes
    assign req_byte[k] = req_data[8*k +: 8];
  end

  function automatic logic [W-1:0] inc_idx(input logic [W-1:0] i);
    return (32'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // While locked only the owner may compete; its bit is the only candidate.
  always_comb begin
    cand = req;
    if (locked) begin
      cand = req & (N_REQ'(1) << owner);
    end
  end

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req       (cand),
    .ptr       (ptr),
    .valid     (pick_valid),
    .grant_idx (pick_idx)
  );

  assign busy = (state != UA_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UA_IDLE;
      txready_m <= 1'b0;
      txready_s <= 1'b0;
      ptr       <= '0;
      locked    <= 1'b0;
      cnt       <= '0;
      ack       <= '0;
      txdata    <= '0;
      txclk     <= 1'b0;
      owner     <= '0;
      err       <= 1'b0;
    end else begin
      txready_m <= txready;
      txready_s <= txready_m;
      ack       <= '0;
      txclk     <= 1'b0;
      err       <= 1'b0;

      case (state)
        UA_IDLE: begin
          if (txready_s) begin
            if (locked && !req[owner]) begin
              // Owner withdrew mid-packet: release the channel and move the
              // search past it; the next grant happens on the following cycle.
              locked <= 1'b0;
              ptr    <= inc_idx(owner);
            end else if (pick_valid) begin
              txdata <= req_byte[pick_idx];
              ack    <= N_REQ'(1) << pick_idx;
              owner  <= pick_idx;
              if (req_last[pick_idx]) begin
                locked <= 1'b0;
                ptr    <= inc_idx(pick_idx);
              end else begin
                locked <= 1'b1;
              end
              state <= UA_STROBE;
            end
          end
        end

        UA_STROBE: begin
          txclk <= 1'b1;
          cnt   <= '0;
          state <= UA_WAIT_BUSY;
        end

        UA_WAIT_BUSY: begin
          if (!txready_s) begin
            state <= UA_WAIT_IDLE;
          end else if (cnt == TMAX) begin
            // Counter holds TIMEOUT for one cycle before the abort, so err
            // lands TIMEOUT+1 cycles after the txclk cycle.
            err    <= 1'b1;
            locked <= 1'b0;
            state  <= UA_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        UA_WAIT_IDLE: begin
          if (txready_s) begin
            state <= UA_IDLE;
          end
        end

        default: state <= UA_IDLE;
      endcase
    end
  end

endmodule
